// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST engine for the RISC16 on-chip SRAM.
// Sequence: M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1),
//           M4 down(r1,w0), M5 up(r0); 10*N SRAM ops back to back.
// Read data returns one cycle after the strobe, so each read registers its
// expected word and is compared in the following cycle. A one-cycle DRAIN
// state checks the final M5 read.
// Optional build macro MBIST_FAIL_CAPTURE_EN: record the address and element
// of the first failing read on fail_addr/fail_elem (tied to 0 otherwise).
module mbist_march_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mbist_start,
  output logic              mbist_done,
  output logic              mbist_fail,
  output logic              mbist_active,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              fail_q, fail_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;

  logic              run;
  logic              start_run;
  logic              two_op;
  logic              is_down;
  logic              op_write;
  logic              last_addr;
  logic              mismatch;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  // Decode the current march element into op type, direction and data words.
  always_comb begin
    run       = (state_q == ST_RUN);
    start_run = (state_q == ST_IDLE) && mbist_start;
    two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
    if (elem_q == 3'd0) begin
      op_write = 1'b1;
    end else if (two_op) begin
      op_write = phase_q;
    end else begin
      op_write = 1'b0;
    end
    wr_word   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : '0;
    rd_word   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0;
    last_addr = is_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    mismatch  = cmp_valid_q && (mem_rdata != cmp_exp_q);
  end

  // Next-state logic: state machine, address/element walk and compare pipe.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    fail_d      = fail_q | mismatch;
    cmp_valid_d = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    case (state_q)
      ST_IDLE: begin
        if (mbist_start) begin
          state_d = ST_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          phase_d = 1'b0;
          fail_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!op_write) begin
          cmp_valid_d = 1'b1;
          cmp_exp_d   = rd_word;
        end
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = is_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
          end else if (elem_q == 3'd5) begin
            state_d = ST_DRAIN;
          end else begin
            // Next element starts at its own first address: top for M3/M4.
            elem_d = elem_q + 3'd1;
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!mbist_start) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and counter registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      fail_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      fail_q      <= fail_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

  assign mem_en       = run;
  assign mem_we       = run & op_write;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wr_word;
  assign mbist_active = run || (state_q == ST_DRAIN);
  assign mbist_done   = (state_q == ST_DONE);
  assign mbist_fail   = fail_q;

`ifdef MBIST_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [2:0]        cmp_elem_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;

  // Tag each read with its location, and latch the tag of the first mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      if (run && !op_write) begin
        cmp_addr_q <= addr_q;
        cmp_elem_q <= elem_q;
      end
      if (start_run) begin
        fail_addr_q <= '0;
        fail_elem_q <= 3'd0;
      end else if (mismatch && !fail_q) begin
        fail_addr_q <= cmp_addr_q;
        fail_elem_q <= cmp_elem_q;
      end
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
`else
  logic unused_start_run;
  assign unused_start_run = start_run;
  assign fail_addr        = '0;
  assign fail_elem        = 3'd0;
`endif

endmodule
